hit_recorder: RTL and testbench
===============================

Name: hit_recorder

Overview:
- Parametrised successor to the live-play key capture block.
- Converts one-hot note/length keypads and octave up/down buttons into timestamped note events, and queues them in an internal FIFO with a valid/ready pop interface.
- Sits between the debounced keypad inputs and the recorder/playback sequencer.
- Adds saturating octave limits, press-edge detection, relative timestamps and overflow reporting.

Parameters:
- NOTE_KEYS, 7, width of note one-hot keypad.
- LENGTH_KEYS, 7, width of length one-hot keypad.
- NOTE_BITS, 3, note index width; must satisfy 2^NOTE_BITS > NOTE_KEYS.
- LENGTH_BITS, 3, length index width; must satisfy 2^LENGTH_BITS >= LENGTH_KEYS.
- OCTAVE_BITS, 3, octave width.
- OCT_MIN, 1, lowest legal octave.
- OCT_MAX, 6, highest legal octave.
- CLOCK_BITS, 32, timestamp width.
- FIFO_DEPTH, 8, event queue depth; power of two, >= 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  capture session enable
- octave_in  in  OCTAVE_BITS  starting octave, loaded on en rise
- oct_up  in  1  octave-up button (level)
- oct_down  in  1  octave-down button (level)
- note_key  in  NOTE_KEYS  one-hot note keypad
- length_key  in  LENGTH_KEYS  one-hot length keypad
- system_clock  in  CLOCK_BITS  free-running time counter
- ev_valid  out  1  FIFO head valid
- ev_ready  in  1  consumer pops head when ev_valid && ev_ready
- ev_octave  out  OCTAVE_BITS  head event octave
- ev_note  out  NOTE_BITS  head event note index
- ev_length  out  LENGTH_BITS  head event length index
- ev_time  out  CLOCK_BITS  head event time, relative to session start
- ev_count  out  $clog2(FIFO_DEPTH)+1  queued event count
- overflow  out  1  sticky: an event was dropped
- octave  out  OCTAVE_BITS  current octave
- length  out  LENGTH_BITS  current length index

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: all outputs 0, FIFO empty, state IDLE, octave = OCT_MIN, length = 0.
- States:
  - IDLE: en=0.
  - ARMED: en=1, no note key held.
  - HELD: en=1, note key held.
- IDLE->ARMED: on en=1.
  - octave <= octave_in clamped to [OCT_MIN,OCT_MAX].
  - start_time <= system_clock.
  - length <= 0.
  - overflow <= 0.
  - FIFO flushed.
- Any state -> IDLE: en=0 at any clock; FIFO flushed, ev_valid=0 next cycle.
- Key decoding:
  - A key is valid only when exactly one bit is set; zero or multiple bits = no key.
  - Index = bit position, LSB = 0.
- ARMED->HELD: on a valid note key.
  - Push {octave, index, length, system_clock - start_time}; modulo 2^CLOCK_BITS.
  - Push uses register values before any same-cycle octave/length update.
- HELD->ARMED: when note_key == 0. Multi-bit or different-key transitions while in HELD push nothing; a new press requires release first.
- length: updates to a valid length_key index on any en=1 cycle; otherwise holds.
- Octave buttons:
  - Rising edges detected on a registered copy of the button; one step per press.
  - Saturate at OCT_MIN/OCT_MAX.
  - Up and down edges in the same cycle = no change.
  - Inactive in IDLE.
- FIFO:
  - Push and pop in the same cycle are both performed and ev_count is unchanged; this includes when full.
  - Push when full without pop: event dropped, overflow <= 1; sticky until next en rise or reset.
  - Pop when empty: ignored.
  - Head outputs are registered/stable while ev_valid && !ev_ready.
- Latency: key press sampled at edge N -> ev_valid=1 after edge N+1 when FIFO was empty.
- Reset mid-session: immediate return to reset values; no event survives.

Optional Feature:
- Macro: HIT_REST_EN.
- Defined: the HELD->ARMED transition pushes a rest event with ev_note = NOTE_KEYS (all-ones-safe index), current octave and length, and the release timestamp; overflow rules apply identically.
- Undefined: releases push nothing; ev_note never equals NOTE_KEYS.

Test Plan:
- Reset, en=1, octave_in=4, system_clock=100; at clock 130 set note_key=0000100 for 3 cycles -> exactly one event {4,2,0,30}, ev_count=1.
- Octave limits: octave_in=6, oct_up pressed twice -> octave stays 6. oct_down held 10 cycles -> octave 5. oct_up and oct_down rising in the same cycle -> unchanged.
- Invalid keys: note_key=0000110 -> no event. Hold 0000001 then switch to 0000010 without release -> one event only. Release, then press 0000010 -> second event with note=1.
- Overflow: ev_ready=0, 9 distinct presses with FIFO_DEPTH=8 -> ev_count=8, overflow=1, head is the first press. Pop all -> ev_valid=0. en toggle -> overflow=0.
- Simultaneous push/pop with FIFO full -> ev_count stays 8, overflow stays 0, ordering preserved.
- HIT_REST_EN: press note 3 at t=10, release at t=25 -> events {note 3, t 10} then {note 7, t 25}. Without the macro -> only the first event.

Source files
------------

// File: rtl/hit_recorder.sv
// ============================================================================
// hit_recorder
// ----------------------------------------------------------------------------
// Live-play key capture. One-hot note and length keypads plus octave up/down
// buttons are turned into timestamped note events. The events are queued in
// an internal FIFO, and the consumer pops them through a valid/ready interface.
//
// A capture session runs while en is high. When en rises, the block loads
// the starting octave (clamped to the legal range), records the session start
// time, clears the current length and the overflow flag, and empties the
// queue. When en drops, the session ends and the queue is flushed.
//
// Optional build macro:
//   HIT_REST_EN  - when defined, releasing a held note key also queues a rest
//                  event. Its note index is NOTE_KEYS and it carries the
//                  current octave, the current length and the release time.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   en             capture session enable
//   octave_in      starting octave, loaded when en rises
//   oct_up/down    octave buttons (levels; one step per press)
//   note_key       one-hot note keypad
//   length_key     one-hot length keypad
//   system_clock   free-running time counter
//   ev_valid       queue head valid
//   ev_ready       consumer pops the head when ev_valid && ev_ready
//   ev_octave, ev_note, ev_length, ev_time
//                  head event fields; ev_time is relative to session start
//   ev_count       number of queued events
//   overflow       sticky flag: an event was dropped because the queue was full
//   octave         current octave
//   length         current length index
// ============================================================================
module hit_recorder #(
    parameter int NOTE_KEYS   = 7,
    parameter int LENGTH_KEYS = 7,
    parameter int NOTE_BITS   = 3,
    parameter int LENGTH_BITS = 3,
    parameter int OCTAVE_BITS = 3,
    parameter int OCT_MIN     = 1,
    parameter int OCT_MAX     = 6,
    parameter int CLOCK_BITS  = 32,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en,
    input  logic [OCTAVE_BITS-1:0]            octave_in,
    input  logic                              oct_up,
    input  logic                              oct_down,
    input  logic [NOTE_KEYS-1:0]              note_key,
    input  logic [LENGTH_KEYS-1:0]            length_key,
    input  logic [CLOCK_BITS-1:0]             system_clock,
    output logic                              ev_valid,
    input  logic                              ev_ready,
    output logic [OCTAVE_BITS-1:0]            ev_octave,
    output logic [NOTE_BITS-1:0]              ev_note,
    output logic [LENGTH_BITS-1:0]            ev_length,
    output logic [CLOCK_BITS-1:0]             ev_time,
    output logic [$clog2(FIFO_DEPTH):0]       ev_count,
    output logic                              overflow,
    output logic [OCTAVE_BITS-1:0]            octave,
    output logic [LENGTH_BITS-1:0]            length
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [OCTAVE_BITS-1:0] OCT_LO     = OCTAVE_BITS'(OCT_MIN);
    localparam logic [OCTAVE_BITS-1:0] OCT_HI     = OCTAVE_BITS'(OCT_MAX);
    localparam logic [OCTAVE_BITS-1:0] OCT_STEP   = OCTAVE_BITS'(1);
    localparam logic [CNT_W-1:0]       FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]       PTR_STEP   = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HELD  = 2'd2
    } state_t;

    typedef struct packed {
        logic [OCTAVE_BITS-1:0] octave;
        logic [NOTE_BITS-1:0]   note;
        logic [LENGTH_BITS-1:0] length;
        logic [CLOCK_BITS-1:0]  stamp;
    } event_t;

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    state_t                 state_reg;
    logic [OCTAVE_BITS-1:0] octave_reg;
    logic [OCTAVE_BITS-1:0] octave_next;
    logic [LENGTH_BITS-1:0] length_reg;
    logic [CLOCK_BITS-1:0]  start_time_reg;
    logic                   up_prev_reg;
    logic                   down_prev_reg;

    // An event is built in the cycle the key is sampled and is written into
    // the queue one cycle later. This gives the one-cycle press-to-valid
    // latency while the timestamp still reflects the sampling edge.
    logic                   stage_valid_reg;
    event_t                 stage_reg;

    // ------------------------------------------------------------------
    // Queue registers
    // ------------------------------------------------------------------
    event_t                 mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_reg;
    logic [PTR_W-1:0]       rd_ptr_reg;
    logic [CNT_W-1:0]       count_reg;
    logic                   overflow_reg;

    // ------------------------------------------------------------------
    // Keypad decoding: a key is valid only when exactly one bit is set.
    // ------------------------------------------------------------------
    logic                   note_valid;
    logic [NOTE_BITS-1:0]   note_idx;
    logic                   length_valid;
    logic [LENGTH_BITS-1:0] length_idx;

    always_comb begin
        note_idx = '0;
        for (int i = 0; i < NOTE_KEYS; i++) begin
            if (note_key[i]) begin
                note_idx = NOTE_BITS'(i);
            end
        end
        note_valid = $onehot(note_key);
    end

    always_comb begin
        length_idx = '0;
        for (int i = 0; i < LENGTH_KEYS; i++) begin
            if (length_key[i]) begin
                length_idx = LENGTH_BITS'(i);
            end
        end
        length_valid = $onehot(length_key);
    end

    // ------------------------------------------------------------------
    // Session and octave helpers
    // ------------------------------------------------------------------
    logic                   session_active;
    logic                   up_edge;
    logic                   down_edge;
    logic [OCTAVE_BITS-1:0] octave_clamped;
    logic [CLOCK_BITS-1:0]  elapsed;

    assign session_active = en && (state_reg != IDLE);
    assign up_edge        = oct_up && !up_prev_reg;
    assign down_edge      = oct_down && !down_prev_reg;
    // Wraps modulo 2^CLOCK_BITS, so the counter may roll over mid-session.
    assign elapsed        = system_clock - start_time_reg;

    always_comb begin
        if (octave_in < OCT_LO) begin
            octave_clamped = OCT_LO;
        end else if (octave_in > OCT_HI) begin
            octave_clamped = OCT_HI;
        end else begin
            octave_clamped = octave_in;
        end
    end

    // When both buttons rise in the same cycle, the presses cancel.
    always_comb begin
        octave_next = octave_reg;
        if (up_edge && !down_edge && (octave_reg < OCT_HI)) begin
            octave_next = octave_reg + OCT_STEP;
        end else if (down_edge && !up_edge && (octave_reg > OCT_LO)) begin
            octave_next = octave_reg - OCT_STEP;
        end
    end

    // ------------------------------------------------------------------
    // Capture FSM with registered octave/length and event staging
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            octave_reg      <= OCT_LO;
            length_reg      <= '0;
            start_time_reg  <= '0;
            up_prev_reg     <= 1'b0;
            down_prev_reg   <= 1'b0;
            stage_valid_reg <= 1'b0;
            stage_reg       <= '0;
        end else begin
            // The edge detectors keep tracking the buttons outside a
            // session. A button already held when en rises does not step.
            up_prev_reg     <= oct_up;
            down_prev_reg   <= oct_down;
            stage_valid_reg <= 1'b0;

            if (!en) begin
                state_reg <= IDLE;
            end else if (state_reg == IDLE) begin
                state_reg      <= ARMED;
                octave_reg     <= octave_clamped;
                start_time_reg <= system_clock;
                length_reg     <= '0;
            end else begin
                if (length_valid) begin
                    length_reg <= length_idx;
                end
                octave_reg <= octave_next;

                // Event fields use the register values from before this
                // cycle's octave/length update.
                case (state_reg)
                    ARMED: begin
                        if (note_valid) begin
                            state_reg       <= HELD;
                            stage_valid_reg <= 1'b1;
                            stage_reg       <= '{octave: octave_reg,
                                                 note:   note_idx,
                                                 length: length_reg,
                                                 stamp:  elapsed};
                        end
                    end
                    HELD: begin
                        // A multi-bit or different key while held is not
                        // a new press. Only a full release re-arms.
                        if (note_key == '0) begin
                            state_reg <= ARMED;
`ifdef HIT_REST_EN
                            stage_valid_reg <= 1'b1;
                            stage_reg       <= '{octave: octave_reg,
                                                 note:   NOTE_BITS'(NOTE_KEYS),
                                                 length: length_reg,
                                                 stamp:  elapsed};
`endif
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Event queue
    // ------------------------------------------------------------------
    logic queue_full;
    logic do_pop;
    logic do_write;

    assign ev_valid   = (count_reg != '0);
    assign queue_full = (count_reg == FULL_COUNT);
    assign do_pop     = session_active && ev_valid && ev_ready;
    // When the queue is full, a simultaneous pop frees the slot the push uses.
    assign do_write   = session_active && stage_valid_reg && (!queue_full || do_pop);

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr_reg] <= stage_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if (!session_active) begin
            // Outside a session the queue stays empty. The overflow flag
            // survives the idle time and is cleared only at the next session
            // start.
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            if (en) begin
                overflow_reg <= 1'b0;
            end
        end else begin
            if (do_write) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_STEP;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_STEP;
            end
            count_reg <= count_reg + CNT_W'(do_write) - CNT_W'(do_pop);
            if (stage_valid_reg && queue_full && !do_pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The head fields read zero while the queue is empty, so the
    // fields never show uninitialised storage.
    // ------------------------------------------------------------------
    event_t head;
    assign head      = ev_valid ? mem[rd_ptr_reg] : '0;

    assign ev_octave = head.octave;
    assign ev_note   = head.note;
    assign ev_length = head.length;
    assign ev_time   = head.stamp;
    assign ev_count  = count_reg;
    assign overflow  = overflow_reg;
    assign octave    = octave_reg;
    assign length    = length_reg;

endmodule

// File: tb/tb_hit_recorder.sv
// ============================================================================
// tb_hit_recorder
// ----------------------------------------------------------------------------
// Self-checking bench for hit_recorder with default parameters. A
// queue-based reference model follows the behavioural rules: sessions,
// press/release, octave saturation and FIFO drop/pop. Directed scenario tasks
// and a randomized run compare the DUT outputs against the model and against
// literal expectations. Define HIT_REST_EN for both the bench and the design
// to check the rest-event build.
// ============================================================================
module tb_hit_recorder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [2:0]  octave_in;
    logic        oct_up;
    logic        oct_down;
    logic [6:0]  note_key;
    logic [6:0]  length_key;
    logic [31:0] system_clock;
    logic        ev_valid;
    logic        ev_ready;
    logic [2:0]  ev_octave;
    logic [2:0]  ev_note;
    logic [2:0]  ev_length;
    logic [31:0] ev_time;
    logic [3:0]  ev_count;
    logic        overflow;
    logic [2:0]  octave;
    logic [2:0]  length;

    int n_tests = 0;
    int n_fail  = 0;

    hit_recorder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .octave_in    (octave_in),
        .oct_up       (oct_up),
        .oct_down     (oct_down),
        .note_key     (note_key),
        .length_key   (length_key),
        .system_clock (system_clock),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_octave    (ev_octave),
        .ev_note      (ev_note),
        .ev_length    (ev_length),
        .ev_time      (ev_time),
        .ev_count     (ev_count),
        .overflow     (overflow),
        .octave       (octave),
        .length       (length)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [2:0]  oct;
        logic [2:0]  note;
        logic [2:0]  len;
        logic [31:0] t;
    } ev_t;

    ev_t         q[$];
    ev_t         pend;
    bit          pend_v;
    bit          m_sess;
    bit          m_held;
    bit          m_ovf;
    logic [2:0]  m_oct;
    logic [2:0]  m_len;
    logic [31:0] m_start;
    bit          m_up_p;
    bit          m_dn_p;
    logic [31:0] sess_start;

    function automatic void model_reset();
        q.delete();
        pend_v  = 0;
        m_sess  = 0;
        m_held  = 0;
        m_ovf   = 0;
        m_oct   = 3'd1;
        m_len   = 3'd0;
        m_start = '0;
        m_up_p  = 0;
        m_dn_p  = 0;
    endfunction

    // Applies one active clock edge using the inputs present before it.
    function automatic void model_step();
        bit up_e;
        bit dn_e;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!en) begin
            m_sess = 0;
            m_held = 0;
            q.delete();
            pend_v = 0;
        end else if (!m_sess) begin
            m_sess  = 1;
            m_held  = 0;
            m_oct   = (octave_in < 3'd1) ? 3'd1 : (octave_in > 3'd6) ? 3'd6 : octave_in;
            m_start = system_clock;
            m_len   = 3'd0;
            m_ovf   = 0;
            q.delete();
            pend_v  = 0;
        end else begin
            // An event built at the previous edge lands now, after this
            // edge's pop.
            if (q.size() > 0 && ev_ready) void'(q.pop_front());
            if (pend_v) begin
                if (q.size() < 8) q.push_back(pend);
                else m_ovf = 1;
            end
            pend_v = 0;
            if (!m_held && $countones(note_key) == 1) begin
                pend   = '{oct: m_oct, note: 3'($clog2(note_key)), len: m_len,
                           t: system_clock - m_start};
                pend_v = 1;
                m_held = 1;
            end else if (m_held && note_key == 7'd0) begin
                m_held = 0;
`ifdef HIT_REST_EN
                pend   = '{oct: m_oct, note: 3'd7, len: m_len, t: system_clock - m_start};
                pend_v = 1;
`endif
            end
            if ($countones(length_key) == 1) m_len = 3'($clog2(length_key));
            up_e = oct_up && !m_up_p;
            dn_e = oct_down && !m_dn_p;
            if (up_e && !dn_e && m_oct < 3'd6) m_oct = m_oct + 3'd1;
            if (dn_e && !up_e && m_oct > 3'd1) m_oct = m_oct - 3'd1;
        end
        m_up_p = oct_up;
        m_dn_p = oct_down;
    endfunction

`ifdef HIT_REST_EN
    localparam bit REST = 1'b1;
`else
    localparam bit REST = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        system_clock = system_clock + 32'd1;
    endtask

    task automatic start_session(input logic [2:0] oin);
        en = 0; note_key = 0; oct_up = 0; oct_down = 0; ev_ready = 0; length_key = 0;
        cycle();
        en = 1; octave_in = oin; sess_start = system_clock;
        cycle();
    endtask

    // ------------------------------------------------------------------
    // Scenario tasks
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 0; en = 0; octave_in = 0; oct_up = 0; oct_down = 0;
        note_key = 0; length_key = 0; system_clock = 0; ev_ready = 0;
        model_reset();
        cycle(); cycle();
        n_tests++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ev_valid got %0b want 0", ev_valid); end
        n_tests++; if (ev_count !== 4'd0) begin n_fail++; $display("FAIL reset_ev_count got %0d want 0", ev_count); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        n_tests++; if (octave !== 3'd1) begin n_fail++; $display("FAIL reset_octave got %0d want 1", octave); end
        n_tests++; if (length !== 3'd0) begin n_fail++; $display("FAIL reset_length got %0d want 0", length); end
        n_tests++; if ({ev_octave, ev_note, ev_length, ev_time} !== 41'd0) begin
            n_fail++; $display("FAIL reset_head got %0h want 0", {ev_octave, ev_note, ev_length, ev_time});
        end
        rst_n = 1;
        cycle();
        $display("[TB] test_reset done");
    endtask

    task automatic test_basic();
        en = 0; cycle();
        system_clock = 32'd100; en = 1; octave_in = 3'd4;
        cycle();
        for (int g = 0; g < 40 && system_clock != 32'd130; g++) cycle();
        note_key = 7'b0000100;
        cycle();
        n_tests++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency got %0b want 0", ev_valid); end
        cycle();
        n_tests++; if (ev_valid !== 1'b1 || ev_count !== 4'd1) begin
            n_fail++; $display("FAIL basic_valid got valid=%0b count=%0d want 1/1", ev_valid, ev_count);
        end
        n_tests++; if ({ev_octave, ev_note, ev_length, ev_time} !== {3'd4, 3'd2, 3'd0, 32'd30}) begin
            n_fail++; $display("FAIL basic_event got {%0d,%0d,%0d,%0d} want {4,2,0,30}", ev_octave, ev_note, ev_length, ev_time);
        end
        cycle();
        note_key = 0;
        cycle(); cycle();
        n_tests++; if (ev_count !== (REST ? 4'd2 : 4'd1)) begin
            n_fail++; $display("FAIL basic_single_event got %0d want %0d", ev_count, REST ? 2 : 1);
        end
        $display("[TB] test_basic done");
    endtask

    task automatic test_octave();
        start_session(3'd6);
        for (int i = 0; i < 2; i++) begin oct_up = 1; cycle(); oct_up = 0; cycle(); end
        n_tests++; if (octave !== 3'd6) begin n_fail++; $display("FAIL octave_sat_high got %0d want 6", octave); end
        oct_down = 1;
        for (int i = 0; i < 10; i++) cycle();
        oct_down = 0; cycle();
        n_tests++; if (octave !== 3'd5) begin n_fail++; $display("FAIL octave_held_down got %0d want 5", octave); end
        oct_up = 1; oct_down = 1; cycle();
        oct_up = 0; oct_down = 0; cycle();
        n_tests++; if (octave !== 3'd5) begin n_fail++; $display("FAIL octave_both got %0d want 5", octave); end
        start_session(3'd7);
        n_tests++; if (octave !== 3'd6) begin n_fail++; $display("FAIL octave_clamp_high got %0d want 6", octave); end
        start_session(3'd0);
        n_tests++; if (octave !== 3'd1) begin n_fail++; $display("FAIL octave_clamp_low got %0d want 1", octave); end
        oct_down = 1; cycle(); oct_down = 0; cycle();
        n_tests++; if (octave !== 3'd1) begin n_fail++; $display("FAIL octave_sat_low got %0d want 1", octave); end
        oct_up = 1; cycle(); oct_up = 0; cycle();
        n_tests++; if (octave !== 3'd2) begin n_fail++; $display("FAIL octave_step_up got %0d want 2", octave); end
        $display("[TB] test_octave done");
    endtask

    task automatic test_invalid();
        start_session(3'd3);
        length_key = 7'b0001000; cycle();
        length_key = 7'b0110000; cycle();
        n_tests++; if (length !== 3'd3) begin n_fail++; $display("FAIL length_hold got %0d want 3", length); end
        length_key = 0;
        note_key = 7'b0000110; cycle(); cycle(); cycle();
        n_tests++; if (ev_count !== 4'd0) begin n_fail++; $display("FAIL invalid_multi got %0d want 0", ev_count); end
        note_key = 0; cycle();
        note_key = 7'b0000001; cycle();
        note_key = 7'b0000010; cycle(); cycle();
        note_key = 0; cycle();
        note_key = 7'b0000010; cycle(); cycle(); cycle();
        n_tests++; if (ev_count !== (REST ? 4'd3 : 4'd2)) begin
            n_fail++; $display("FAIL invalid_switch got %0d want %0d", ev_count, REST ? 3 : 2);
        end
        n_tests++; if (ev_note !== 3'd0 || ev_length !== 3'd3) begin
            n_fail++; $display("FAIL invalid_first got note=%0d len=%0d want 0/3", ev_note, ev_length);
        end
        ev_ready = 1; cycle(); ev_ready = 0;
        n_tests++; if (ev_note !== (REST ? 3'd7 : 3'd1)) begin
            n_fail++; $display("FAIL invalid_second got %0d want %0d", ev_note, REST ? 7 : 1);
        end
        $display("[TB] test_invalid done");
    endtask

    task automatic test_overflow();
        start_session(3'd2);
        for (int i = 0; i < 9; i++) begin
            note_key = 7'(1 << (i % 7)); cycle();
            note_key = 0; cycle();
        end
        cycle(); cycle();
        n_tests++; if (ev_count !== 4'd8 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL overflow_full got count=%0d ovf=%0b want 8/1", ev_count, overflow);
        end
        n_tests++; if (ev_valid !== 1'b1 || ev_note !== 3'd0 || ev_octave !== 3'd2) begin
            n_fail++; $display("FAIL overflow_head got valid=%0b note=%0d oct=%0d want 1/0/2", ev_valid, ev_note, ev_octave);
        end
        ev_ready = 1;
        for (int i = 0; i < 10; i++) cycle();
        ev_ready = 0;
        n_tests++; if (ev_valid !== 1'b0 || ev_count !== 4'd0) begin
            n_fail++; $display("FAIL overflow_drain got valid=%0b count=%0d want 0/0", ev_valid, ev_count);
        end
        en = 0; cycle();
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky got %0b want 1", overflow); end
        en = 1; cycle();
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_clear got %0b want 0", overflow); end
        $display("[TB] test_overflow done");
    endtask

    task automatic test_full_push_pop();
        ev_t exp_head;
        logic [2:0] last_note;
        start_session(3'd5);
        for (int k = 0; k < 64; k++) begin
            note_key = (k % 4 < 2) ? 7'(1 << ((k / 4) % 7)) : 7'd0;
            cycle();
            if (k % 4 == 3 && q.size() >= 8) break;
        end
        n_tests++; if (ev_count !== 4'd8) begin n_fail++; $display("FAIL fullpp_fill got %0d want 8", ev_count); end
        exp_head = q[1];
        note_key = 7'b0000100; cycle();
        ev_ready = 1; cycle(); ev_ready = 0;
        n_tests++; if (ev_count !== 4'd8 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL fullpp_count got count=%0d ovf=%0b want 8/0", ev_count, overflow);
        end
        n_tests++; if ({ev_octave, ev_note, ev_length, ev_time} !== {exp_head.oct, exp_head.note, exp_head.len, exp_head.t}) begin
            n_fail++; $display("FAIL fullpp_head got note=%0d t=%0d want note=%0d t=%0d", ev_note, ev_time, exp_head.note, exp_head.t);
        end
        last_note = 3'd0;
        ev_ready = 1;
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (q.size() == 0 || {ev_valid, ev_note, ev_time} !== {1'b1, q[0].note, q[0].t}) begin
                n_fail++; $display("FAIL fullpp_order%0d got note=%0d t=%0d", i, ev_note, ev_time);
            end
            last_note = ev_note;
            cycle();
        end
        ev_ready = 0;
        n_tests++; if (last_note !== 3'd2 || ev_valid !== 1'b0) begin
            n_fail++; $display("FAIL fullpp_tail got note=%0d valid=%0b want 2/0", last_note, ev_valid);
        end
        $display("[TB] test_full_push_pop done");
    endtask

    task automatic test_rest();
        start_session(3'd4);
        for (int g = 0; g < 40 && (system_clock - sess_start) != 32'd10; g++) cycle();
        note_key = 7'b0001000; cycle();
        for (int g = 0; g < 40 && (system_clock - sess_start) != 32'd25; g++) cycle();
        note_key = 0; cycle(); cycle(); cycle();
        n_tests++; if (ev_count !== (REST ? 4'd2 : 4'd1)) begin
            n_fail++; $display("FAIL rest_count got %0d want %0d", ev_count, REST ? 2 : 1);
        end
        n_tests++; if (ev_note !== 3'd3 || ev_time !== 32'd10) begin
            n_fail++; $display("FAIL rest_press got note=%0d t=%0d want 3/10", ev_note, ev_time);
        end
        ev_ready = 1; cycle(); ev_ready = 0;
        if (REST) begin
            n_tests++; if (ev_note !== 3'd7 || ev_time !== 32'd25 || ev_octave !== 3'd4) begin
                n_fail++; $display("FAIL rest_event got note=%0d t=%0d oct=%0d want 7/25/4", ev_note, ev_time, ev_octave);
            end
        end else begin
            n_tests++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL rest_absent got %0b want 0", ev_valid); end
        end
        $display("[TB] test_rest done");
    endtask

    task automatic test_mid_reset();
        start_session(3'd5);
        note_key = 7'b0000001; cycle(); cycle();
        rst_n = 0; #1;
        n_tests++; if (ev_valid !== 1'b0 || ev_count !== 4'd0 || octave !== 3'd1) begin
            n_fail++; $display("FAIL mid_reset got valid=%0b count=%0d oct=%0d want 0/0/1", ev_valid, ev_count, octave);
        end
        model_reset();
        note_key = 0; en = 0;
        cycle();
        rst_n = 1;
        cycle();
        $display("[TB] test_mid_reset done");
    endtask

    task automatic test_random();
        system_clock = 32'hFFFF_FFC0;
        start_session(3'($urandom_range(0, 7)));
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 79) != 0);
            octave_in = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0: note_key = 7'd0;
                    1, 2: note_key = 7'(1 << $urandom_range(0, 6));
                    default: note_key = 7'($urandom);
                endcase
            end
            if ($urandom_range(0, 3) == 0)
                length_key = ($urandom_range(0, 1) == 0) ? 7'(1 << $urandom_range(0, 6)) : 7'($urandom);
            if ($urandom_range(0, 3) == 0) oct_up = ~oct_up;
            if ($urandom_range(0, 3) == 0) oct_down = ~oct_down;
            ev_ready = ($urandom_range(0, 2) == 0);
            cycle();
            n_tests++; if ({ev_valid, ev_count, overflow, octave, length} !== {q.size() > 0, 4'(q.size()), m_ovf, m_oct, m_len}) begin
                n_fail++; $display("FAIL rand_state%0d got v=%0b c=%0d o=%0b oct=%0d len=%0d want v=%0b c=%0d o=%0b oct=%0d len=%0d",
                                   i, ev_valid, ev_count, overflow, octave, length, q.size() > 0, q.size(), m_ovf, m_oct, m_len);
            end
            if (q.size() > 0) begin
                n_tests++; if ({ev_octave, ev_note, ev_length, ev_time} !== {q[0].oct, q[0].note, q[0].len, q[0].t}) begin
                    n_fail++; $display("FAIL rand_head%0d got {%0d,%0d,%0d,%0d} want {%0d,%0d,%0d,%0d}", i,
                                       ev_octave, ev_note, ev_length, ev_time, q[0].oct, q[0].note, q[0].len, q[0].t);
                end
            end
        end
        $display("[TB] test_random done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_octave();
        test_invalid();
        test_overflow();
        test_full_push_pop();
        test_rest();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

endmodule
